// File: rtl/nbit_logic_unit.sv
// WIDTH-bit bitwise logic unit with eight operations, optional accumulate mode and
// a 2-entry registered output buffer behind a valid/ready stream interface.
module nbit_logic_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             zero,
  output logic             parity
);

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready depends only on the registered count.
  localparam int EW = WIDTH + 2;

  logic [1:0]       count;
  logic [EW-1:0]    slot0;
  logic [EW-1:0]    slot1;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] r;
  logic [EW-1:0]    new_entry;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {x, zero, parity} = slot0;

  // A clear on the same edge as an accumulate beat makes that beat see zero.
  always_comb begin
    lhs = a;
    if (acc_mode) lhs = acc_clr ? '0 : acc;
  end

  always_comb begin
    r = '0;
    case (op)
      3'd0: r = lhs & b;
      3'd1: r = lhs | b;
      3'd2: r = lhs ^ b;
      3'd3: r = ~(lhs & b);
      3'd4: r = ~(lhs | b);
      3'd5: r = ~(lhs ^ b);
      3'd6: r = ~lhs;
      default: r = lhs;
    endcase
  end

  assign new_entry = {r, (r == '0), ^r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (push && acc_mode) begin
      acc <= r;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

  // slot0 is the head; when empty it keeps the last popped entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      slot0 <= {{WIDTH{1'b0}}, 1'b1, 1'b0};
      slot1 <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            slot0 <= new_entry;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= new_entry;
          end else if (push) begin
            slot1 <= new_entry;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            slot0 <= slot1;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_logic_unit.sv
// Directed bench for nbit_logic_unit: drivers push expected {x,zero,parity} into a
// queue at acceptance, a negedge monitor pops and compares on every delivered beat.
module tb_nbit_logic_unit;

  localparam int W  = 4;
  localparam int EW = W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          acc_mode = 1'b0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  x;
  logic          zero;
  logic          parity;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic          rand_phase = 1'b0;
  logic [W-1:0]  acc_m = '0;

  nbit_logic_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .x(x), .zero(zero), .parity(parity)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Monitor: every delivered beat must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL out_unexpected: got %0h expected no beat", {x, zero, parity});
      end else begin
        check("out_beat", 32'({x, zero, parity}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Caller is just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] top,
                      input logic tam, input logic tclr,
                      input logic [W-1:0] ex, input logic ez, input logic ep);
    bit done = 0;
    in_valid = 1'b1; a = ta; b = tb; op = top; acc_mode = tam; acc_clr = tclr;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back({ex, ez, ep});
        done = 1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance");
    end
    #1;
    in_valid = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [W-1:0] model_op(input logic [2:0] o, input logic [W-1:0] l,
                                            input logic [W-1:0] r);
    case (o)
      3'd0: return l & r;
      3'd1: return l | r;
      3'd2: return l ^ r;
      3'd3: return ~(l & r);
      3'd4: return ~(l | r);
      3'd5: return ~(l ^ r);
      3'd6: return ~l;
      default: return l;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] va [8] = '{4'd1, 4'd7, 4'd6, 4'd14, 4'd8, 4'd9, 4'd12, 4'd3};
    logic         vp [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_x", 32'(x), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_parity", 32'(parity), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // All eight ops with a=3, b=5, back to back.
    for (int i = 0; i < 8; i++) send(4'd3, 4'd5, 3'(i), 1'b0, 1'b0, va[i], 1'b0, vp[i]);
    drain();

    // Accumulate chain after a standalone clear.
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    send(4'd0, 4'd1,  3'd1, 1'b1, 1'b0, 4'd1,  1'b0, 1'b1);
    send(4'd0, 4'd4,  3'd1, 1'b1, 1'b0, 4'd5,  1'b0, 1'b0);
    send(4'd0, 4'd15, 3'd2, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
    send(4'd0, 4'd0,  3'd7, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
    // Clear and accumulate on the same edge: operand is zero.
    send(4'd0, 4'd6,  3'd1, 1'b1, 1'b1, 4'd6,  1'b0, 1'b0);
    send(4'd0, 4'd0,  3'd7, 1'b1, 1'b0, 4'd6,  1'b0, 1'b0);
    drain();

    // Back-pressure: two held beats fill the buffer, the third waits.
    out_ready = 1'b0;
    send(4'd9, 4'd9, 3'd2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    send(4'd1, 4'd2, 3'd1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    fork
      send(4'd12, 4'd10, 3'd2, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
    join_none
    repeat (3) @(negedge clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_hold", 32'({x, zero, parity}), 32'({4'd0, 1'b1, 1'b0}));
    check("bp_queued", 32'(exp_q.size()), 32'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();

    // Reset mid-stream with two beats buffered.
    out_ready = 1'b0;
    send(4'd3, 4'd5, 3'd0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1);
    send(4'd3, 4'd5, 3'd1, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready), 32'd1);
    check("mrst_zero", 32'(zero), 32'd1);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'd3, 4'd5, 3'd2, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0);
    drain();

    // Mixed traffic under random back-pressure; first beat clears the accumulator.
    rand_phase = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] ra, rb, l, res;
      logic [2:0]   ro;
      logic         ram, rclr;
      ra = W'($urandom_range(0, 15)); rb = W'($urandom_range(0, 15));
      ro = 3'($urandom_range(0, 7));
      ram = ($urandom_range(0, 1) == 1);
      rclr = (i == 0) || ($urandom_range(0, 9) == 0);
      l = ram ? (rclr ? '0 : acc_m) : ra;
      res = model_op(ro, l, rb);
      if (ram) acc_m = res;
      else if (rclr) acc_m = '0;
      send(ra, rb, ro, ram, rclr, res, (res == '0), ^res);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_phase = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
